// File: rtl/morty_pkg.sv
// morty_pkg: shared constants and source encodings for the writeback arbiter.
//   XLEN  - writeback data width
//   AW    - register address width
//   NREGS - architectural register count (2**AW)
//   src_e - writeback source identifier (ALU = 0, LSU = 1)
package morty_pkg;

  localparam int XLEN  = 32;
  localparam int AW    = 5;
  localparam int NREGS = 32;

  typedef enum logic {
    SRC_ALU = 1'b0,
    SRC_LSU = 1'b1
  } src_e;

endpackage

// File: rtl/morty_scoreboard.sv
// morty_scoreboard: busy-register scoreboard used by decode to stall on
// results still in flight.
//   clk, rst_n            - clock, asynchronous active-low reset
//   issue_valid, issue_rd - decode issues a producer of issue_rd
//   query_rs1, query_rs2  - decode source operands
//   commit_valid/rd       - register-file write happening this cycle
//   flush                 - clear every busy bit
//   hazard                - combinational stall request
module morty_scoreboard #(
  parameter int AW    = morty_pkg::AW,
  parameter int NREGS = morty_pkg::NREGS
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          issue_valid,
  input  logic [AW-1:0] issue_rd,
  input  logic [AW-1:0] query_rs1,
  input  logic [AW-1:0] query_rs2,
  input  logic          commit_valid,
  input  logic [AW-1:0] commit_rd,
  input  logic          flush,
  output logic          hazard
);

  logic [NREGS-1:0] busy;
  logic [NREGS-1:0] busy_next;
  logic             rs1_busy;
  logic             rs2_busy;
  logic             rd_busy;
  logic             do_set;

  // No bypass: a register committing this cycle still reads busy, matching
  // the register file's read timing.
  always_comb begin
    rs1_busy = (query_rs1 != '0) && busy[query_rs1];
    rs2_busy = (query_rs2 != '0) && busy[query_rs2];
    rd_busy  = issue_valid && (issue_rd != '0) && busy[issue_rd];
    hazard   = rs1_busy | rs2_busy | rd_busy;
  end

  assign do_set = issue_valid && (issue_rd != '0) && !hazard && !flush;

  // Clear applied before set so a new producer on the commit edge keeps
  // the register busy.
  always_comb begin
    busy_next = busy;
    if (flush) begin
      busy_next = '0;
    end else begin
      if (commit_valid) busy_next[commit_rd] = 1'b0;
      if (do_set)       busy_next[issue_rd]  = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) busy <= '0;
    else        busy <= busy_next;
  end

endmodule

// File: rtl/morty_wb_arbiter.sv
// morty_wb_arbiter: round-robin arbiter sharing the register-file write port
// between the ALU (src 0) and LSU (src 1), with a registered write stage and
// a busy-register scoreboard for decode hazard detection.
//   clk, rst_n                        - clock, asynchronous active-low reset
//   alu_valid/rd/data, alu_ready      - ALU writeback handshake
//   lsu_valid/rd/data, lsu_ready      - LSU writeback handshake
//   issue_valid, issue_rd             - decode issue of a register producer
//   query_rs1, query_rs2, hazard      - decode hazard query (combinational)
//   flush                             - clears the scoreboard
//   waddr_rd, wdata_rd, we            - registered register-file write port
module morty_wb_arbiter #(
  parameter int XLEN  = morty_pkg::XLEN,
  parameter int AW    = morty_pkg::AW,
  parameter int NREGS = morty_pkg::NREGS
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            alu_valid,
  input  logic [AW-1:0]   alu_rd,
  input  logic [XLEN-1:0] alu_data,
  output logic            alu_ready,
  input  logic            lsu_valid,
  input  logic [AW-1:0]   lsu_rd,
  input  logic [XLEN-1:0] lsu_data,
  output logic            lsu_ready,
  input  logic            issue_valid,
  input  logic [AW-1:0]   issue_rd,
  input  logic [AW-1:0]   query_rs1,
  input  logic [AW-1:0]   query_rs2,
  output logic            hazard,
  input  logic            flush,
  output logic [AW-1:0]   waddr_rd,
  output logic [XLEN-1:0] wdata_rd,
  output logic            we
);

  import morty_pkg::*;

  src_e last_grant;

  // Contested cycles go to the source that did not win last time.
  always_comb begin
    alu_ready = 1'b0;
    lsu_ready = 1'b0;
    if (alu_valid && lsu_valid) begin
      if (last_grant == SRC_LSU) alu_ready = 1'b1;
      else                       lsu_ready = 1'b1;
    end else if (alu_valid) begin
      alu_ready = 1'b1;
    end else if (lsu_valid) begin
      lsu_ready = 1'b1;
    end
  end

  // rd == 0 still consumes the grant but never raises we.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      last_grant <= SRC_LSU;
      waddr_rd   <= '0;
      wdata_rd   <= '0;
      we         <= 1'b0;
    end else if (alu_ready) begin
      last_grant <= SRC_ALU;
      waddr_rd   <= alu_rd;
      wdata_rd   <= alu_data;
      we         <= (alu_rd != '0);
    end else if (lsu_ready) begin
      last_grant <= SRC_LSU;
      waddr_rd   <= lsu_rd;
      wdata_rd   <= lsu_data;
      we         <= (lsu_rd != '0);
    end else begin
      we         <= 1'b0;
    end
  end

  morty_scoreboard #(
    .AW    (AW),
    .NREGS (NREGS)
  ) u_scoreboard (
    .clk          (clk),
    .rst_n        (rst_n),
    .issue_valid  (issue_valid),
    .issue_rd     (issue_rd),
    .query_rs1    (query_rs1),
    .query_rs2    (query_rs2),
    .commit_valid (we),
    .commit_rd    (waddr_rd),
    .flush        (flush),
    .hazard       (hazard)
  );

endmodule

// File: tb/tb_morty_wb_arbiter.sv
// tb_morty_wb_arbiter: directed self-checking bench for morty_wb_arbiter.
// Inputs change 1 time unit after the rising edge; outputs are checked
// after a further settle delay, well away from the next rising edge.
module tb_morty_wb_arbiter;

  logic        clk;
  logic        rst_n;
  logic        alu_valid;
  logic [4:0]  alu_rd;
  logic [31:0] alu_data;
  logic        alu_ready;
  logic        lsu_valid;
  logic [4:0]  lsu_rd;
  logic [31:0] lsu_data;
  logic        lsu_ready;
  logic        issue_valid;
  logic [4:0]  issue_rd;
  logic [4:0]  query_rs1;
  logic [4:0]  query_rs2;
  logic        hazard;
  logic        flush;
  logic [4:0]  waddr_rd;
  logic [31:0] wdata_rd;
  logic        we;

  int n_checks = 0;
  int n_fail   = 0;

  morty_wb_arbiter #(
    .XLEN  (32),
    .AW    (5),
    .NREGS (32)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .alu_valid   (alu_valid),
    .alu_rd      (alu_rd),
    .alu_data    (alu_data),
    .alu_ready   (alu_ready),
    .lsu_valid   (lsu_valid),
    .lsu_rd      (lsu_rd),
    .lsu_data    (lsu_data),
    .lsu_ready   (lsu_ready),
    .issue_valid (issue_valid),
    .issue_rd    (issue_rd),
    .query_rs1   (query_rs1),
    .query_rs2   (query_rs2),
    .hazard      (hazard),
    .flush       (flush),
    .waddr_rd    (waddr_rd),
    .wdata_rd    (wdata_rd),
    .we          (we)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs;
    alu_valid = 1'b0; alu_rd = '0; alu_data = '0;
    lsu_valid = 1'b0; lsu_rd = '0; lsu_data = '0;
    issue_valid = 1'b0; issue_rd = '0;
    query_rs1 = '0; query_rs2 = '0; flush = 1'b0;
  endtask

  task automatic apply_reset;
    idle_inputs();
    rst_n = 1'b0;
    #3;
    rst_n = 1'b1;
  endtask

  task automatic test_reset;
    idle_inputs();
    rst_n = 1'b0;
    query_rs1 = 5'd3;
    query_rs2 = 5'd31;
    #2;
    n_checks++; if (we !== 1'b0) begin n_fail++; $display("FAIL reset_we: got %b want 0", we); end
    n_checks++; if (waddr_rd !== 5'd0) begin n_fail++; $display("FAIL reset_waddr: got %0d want 0", waddr_rd); end
    n_checks++; if (wdata_rd !== 32'h0) begin n_fail++; $display("FAIL reset_wdata: got %h want 0", wdata_rd); end
    n_checks++; if (hazard !== 1'b0) begin n_fail++; $display("FAIL reset_hazard: got %b want 0", hazard); end
    #2;
    rst_n = 1'b1;
    idle_inputs();
  endtask

  task automatic test_single_write;
    tick();
    alu_valid = 1'b1; alu_rd = 5'd5; alu_data = 32'hDEADBEEF;
    #1;
    n_checks++; if (alu_ready !== 1'b1) begin n_fail++; $display("FAIL single_alu_ready: got %b want 1", alu_ready); end
    n_checks++; if (lsu_ready !== 1'b0) begin n_fail++; $display("FAIL single_lsu_ready: got %b want 0", lsu_ready); end
    tick();
    alu_valid = 1'b0; alu_rd = '0; alu_data = '0;
    #1;
    n_checks++; if (we !== 1'b1) begin n_fail++; $display("FAIL single_we: got %b want 1", we); end
    n_checks++; if (waddr_rd !== 5'd5) begin n_fail++; $display("FAIL single_waddr: got %0d want 5", waddr_rd); end
    n_checks++; if (wdata_rd !== 32'hDEADBEEF) begin n_fail++; $display("FAIL single_wdata: got %h want deadbeef", wdata_rd); end
    n_checks++; if (alu_ready !== 1'b0) begin n_fail++; $display("FAIL single_idle_ready: got %b want 0", alu_ready); end
    tick();
    n_checks++; if (we !== 1'b0) begin n_fail++; $display("FAIL single_we_drop: got %b want 0", we); end
    n_checks++; if (waddr_rd !== 5'd5) begin n_fail++; $display("FAIL single_waddr_hold: got %0d want 5", waddr_rd); end
    n_checks++; if (wdata_rd !== 32'hDEADBEEF) begin n_fail++; $display("FAIL single_wdata_hold: got %h want deadbeef", wdata_rd); end
  endtask

  task automatic test_round_robin;
    logic       exp_alu;
    logic [4:0] exp_addr;
    apply_reset();
    tick();
    alu_valid = 1'b1; alu_rd = 5'd1; alu_data = 32'hA1A1A1A1;
    lsu_valid = 1'b1; lsu_rd = 5'd2; lsu_data = 32'hB2B2B2B2;
    for (int i = 0; i < 4; i++) begin
      exp_alu  = (i % 2 == 0);
      exp_addr = exp_alu ? 5'd1 : 5'd2;
      #1;
      n_checks++; if (alu_ready !== exp_alu) begin n_fail++; $display("FAIL rr_alu_ready[%0d]: got %b want %b", i, alu_ready, exp_alu); end
      n_checks++; if (lsu_ready !== !exp_alu) begin n_fail++; $display("FAIL rr_lsu_ready[%0d]: got %b want %b", i, lsu_ready, !exp_alu); end
      tick();
      if (i == 3) begin alu_valid = 1'b0; lsu_valid = 1'b0; end
      #1;
      n_checks++; if (we !== 1'b1) begin n_fail++; $display("FAIL rr_we[%0d]: got %b want 1", i, we); end
      n_checks++; if (waddr_rd !== exp_addr) begin n_fail++; $display("FAIL rr_waddr[%0d]: got %0d want %0d", i, waddr_rd, exp_addr); end
    end
    tick();
    n_checks++; if (we !== 1'b0) begin n_fail++; $display("FAIL rr_we_end: got %b want 0", we); end
  endtask

  task automatic test_hazard_clear;
    apply_reset();
    tick();
    issue_valid = 1'b1; issue_rd = 5'd7;
    #1;
    n_checks++; if (hazard !== 1'b0) begin n_fail++; $display("FAIL haz_issue_free: got %b want 0", hazard); end
    tick();
    issue_valid = 1'b0; query_rs1 = 5'd7;
    #1;
    n_checks++; if (hazard !== 1'b1) begin n_fail++; $display("FAIL haz_raw_rs1: got %b want 1", hazard); end
    query_rs1 = 5'd0; issue_rd = 5'd7;
    #1;
    n_checks++; if (hazard !== 1'b0) begin n_fail++; $display("FAIL haz_rd_no_issue: got %b want 0", hazard); end
    issue_valid = 1'b1;
    #1;
    n_checks++; if (hazard !== 1'b1) begin n_fail++; $display("FAIL haz_waw: got %b want 1", hazard); end
    issue_valid = 1'b0; issue_rd = '0; query_rs1 = 5'd7;
    lsu_valid = 1'b1; lsu_rd = 5'd7; lsu_data = 32'h77777777;
    tick();
    lsu_valid = 1'b0;
    #1;
    n_checks++; if (we !== 1'b1 || waddr_rd !== 5'd7) begin n_fail++; $display("FAIL haz_commit_write: got we=%b addr=%0d want we=1 addr=7", we, waddr_rd); end
    n_checks++; if (hazard !== 1'b1) begin n_fail++; $display("FAIL haz_no_bypass: got %b want 1", hazard); end
    tick();
    n_checks++; if (hazard !== 1'b0) begin n_fail++; $display("FAIL haz_cleared: got %b want 0", hazard); end
    query_rs1 = '0;
  endtask

  task automatic test_same_edge;
    apply_reset();
    tick();
    alu_valid = 1'b1; alu_rd = 5'd3; alu_data = 32'h33333333;
    tick();
    alu_valid = 1'b0;
    issue_valid = 1'b1; issue_rd = 5'd3;
    #1;
    n_checks++; if (we !== 1'b1 || waddr_rd !== 5'd3) begin n_fail++; $display("FAIL same_commit: got we=%b addr=%0d want we=1 addr=3", we, waddr_rd); end
    n_checks++; if (hazard !== 1'b0) begin n_fail++; $display("FAIL same_pre_hazard: got %b want 0", hazard); end
    tick();
    issue_valid = 1'b0; issue_rd = '0; query_rs2 = 5'd3;
    #1;
    n_checks++; if (hazard !== 1'b1) begin n_fail++; $display("FAIL same_set_wins: got %b want 1", hazard); end
    flush = 1'b1;
    tick();
    flush = 1'b0; query_rs2 = '0;
  endtask

  task automatic test_x0;
    apply_reset();
    tick();
    alu_valid = 1'b1; alu_rd = 5'd0; alu_data = 32'h00001234;
    issue_valid = 1'b1; issue_rd = 5'd0;
    #1;
    n_checks++; if (alu_ready !== 1'b1) begin n_fail++; $display("FAIL x0_ready: got %b want 1", alu_ready); end
    tick();
    alu_valid = 1'b0; issue_valid = 1'b0;
    query_rs1 = 5'd0; query_rs2 = 5'd0;
    #1;
    n_checks++; if (we !== 1'b0) begin n_fail++; $display("FAIL x0_we: got %b want 0", we); end
    n_checks++; if (hazard !== 1'b0) begin n_fail++; $display("FAIL x0_hazard: got %b want 0", hazard); end
    // The x0 accept consumed the ALU's turn, so the LSU wins the next contest.
    alu_valid = 1'b1; alu_rd = 5'd8;
    lsu_valid = 1'b1; lsu_rd = 5'd9;
    #1;
    n_checks++; if (lsu_ready !== 1'b1 || alu_ready !== 1'b0) begin n_fail++; $display("FAIL x0_grant_consumed: got alu=%b lsu=%b want alu=0 lsu=1", alu_ready, lsu_ready); end
    alu_valid = 1'b0; lsu_valid = 1'b0;
  endtask

  task automatic test_flush;
    apply_reset();
    tick();
    issue_valid = 1'b1; issue_rd = 5'd4;
    tick();
    issue_rd = 5'd9;
    tick();
    issue_valid = 1'b0; issue_rd = '0;
    query_rs1 = 5'd4; query_rs2 = 5'd9;
    #1;
    n_checks++; if (hazard !== 1'b1) begin n_fail++; $display("FAIL flush_pre_busy: got %b want 1", hazard); end
    query_rs2 = 5'd0;
    #1;
    n_checks++; if (hazard !== 1'b1) begin n_fail++; $display("FAIL flush_pre_busy4: got %b want 1", hazard); end
    query_rs1 = 5'd0; query_rs2 = 5'd9;
    #1;
    n_checks++; if (hazard !== 1'b1) begin n_fail++; $display("FAIL flush_pre_busy9: got %b want 1", hazard); end
    query_rs2 = 5'd0;
    flush = 1'b1; issue_valid = 1'b1; issue_rd = 5'd11;
    tick();
    flush = 1'b0; issue_valid = 1'b0; issue_rd = '0;
    query_rs1 = 5'd4; query_rs2 = 5'd9;
    #1;
    n_checks++; if (hazard !== 1'b0) begin n_fail++; $display("FAIL flush_cleared: got %b want 0", hazard); end
    query_rs1 = 5'd11; query_rs2 = 5'd0;
    #1;
    n_checks++; if (hazard !== 1'b0) begin n_fail++; $display("FAIL flush_set_ignored: got %b want 0", hazard); end
    query_rs1 = 5'd4;
    alu_valid = 1'b1; alu_rd = 5'd4; alu_data = 32'h44444444;
    tick();
    alu_valid = 1'b0;
    #1;
    n_checks++; if (we !== 1'b1 || wdata_rd !== 32'h44444444) begin n_fail++; $display("FAIL stale_write: got we=%b data=%h want we=1 data=44444444", we, wdata_rd); end
    tick();
    n_checks++; if (hazard !== 1'b0) begin n_fail++; $display("FAIL stale_busy: got %b want 0", hazard); end
    query_rs1 = '0;
  endtask

  task automatic test_async_reset;
    tick();
    alu_valid = 1'b1; alu_rd = 5'd6; alu_data = 32'h66666666;
    tick();
    alu_valid = 1'b0;
    #1;
    n_checks++; if (we !== 1'b1) begin n_fail++; $display("FAIL async_pre_we: got %b want 1", we); end
    rst_n = 1'b0;
    #1;
    n_checks++; if (we !== 1'b0) begin n_fail++; $display("FAIL async_we: got %b want 0", we); end
    n_checks++; if (waddr_rd !== 5'd0 || wdata_rd !== 32'h0) begin n_fail++; $display("FAIL async_regs: got addr=%0d data=%h want 0/0", waddr_rd, wdata_rd); end
    #1;
    rst_n = 1'b1;
  endtask

  initial begin
    test_reset();
    test_single_write();
    test_round_robin();
    test_hazard_clear();
    test_same_edge();
    test_x0();
    test_flush();
    test_async_reset();
    tick();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
